// File: rtl/cu_fsm_if.sv
// cu_fsm_if -- bundle of the control unit's decode inputs and control outputs.
//   master : the control FSM (drives enables and instret, samples INTR/opcode/func3)
//   slave  : the datapath side (drives INTR/opcode/func3, consumes enables)
// Signals:
//   INTR       level interrupt request, pre-masked by CSR interrupt enable
//   opcode     instruction bits [6:0]
//   func3      instruction bits [14:12]
//   PCWrite    PC register load enable
//   regWrite   register-file write enable
//   memWE2     data-port write enable
//   memRDEN1   instruction-port read enable
//   memRDEN2   data-port read enable
//   reset      PC clear request
//   csr_WE     CSR write enable
//   int_taken  interrupt entry strobe
//   mret_exec  MRET strobe
//   instret    retired-instruction count
interface cu_fsm_if #(
  parameter int unsigned INSTRET_W = 32
);
  logic                 INTR;
  logic [6:0]           opcode;
  logic [2:0]           func3;
  logic                 PCWrite;
  logic                 regWrite;
  logic                 memWE2;
  logic                 memRDEN1;
  logic                 memRDEN2;
  logic                 reset;
  logic                 csr_WE;
  logic                 int_taken;
  logic                 mret_exec;
  logic [INSTRET_W-1:0] instret;

  modport master (
    input  INTR, opcode, func3,
    output PCWrite, regWrite, memWE2, memRDEN1, memRDEN2,
           reset, csr_WE, int_taken, mret_exec, instret
  );

  modport slave (
    output INTR, opcode, func3,
    input  PCWrite, regWrite, memWE2, memRDEN1, memRDEN2,
           reset, csr_WE, int_taken, mret_exec, instret
  );
endinterface

// File: rtl/cu_fsm.sv
// cu_fsm -- multicycle control unit for an RV32 core.
// Sequences INIT -> FETCH -> EXEC [-> WB for loads] [-> INTR] -> FETCH and
// decodes the opcode/func3 in EXEC into datapath enables. Counts retired
// instructions in instret.
// Ports:
//   CLK  system clock, rising edge
//   RST  asynchronous active-high reset
//   bus  cu_fsm_if master modport (decode inputs, enables, instret)
module cu_fsm #(
  parameter int unsigned INSTRET_W = 32
) (
  input logic      CLK,
  input logic      RST,
  cu_fsm_if.master bus
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } state_t;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_SYSTEM = 7'b1110011
  } opcode_t;

  state_t               state_q;
  state_t               state_d;
  logic                 retire;
  logic [INSTRET_W-1:0] instret_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_INIT;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      // Natural wrap from all-ones to zero is intended.
      if (retire)
        instret_q <= instret_q + 1'b1;
    end
  end

  always_comb begin
    state_d       = ST_INIT;
    retire        = 1'b0;
    bus.PCWrite   = 1'b0;
    bus.regWrite  = 1'b0;
    bus.memWE2    = 1'b0;
    bus.memRDEN1  = 1'b0;
    bus.memRDEN2  = 1'b0;
    bus.reset     = 1'b0;
    bus.csr_WE    = 1'b0;
    bus.int_taken = 1'b0;
    bus.mret_exec = 1'b0;

    case (state_q)
      ST_INIT: begin
        bus.reset = 1'b1;
        state_d   = ST_FETCH;
      end

      ST_FETCH: begin
        bus.memRDEN1 = 1'b1;
        state_d      = ST_EXEC;
      end

      ST_EXEC: begin
        if (bus.opcode == OP_LOAD) begin
          // Loads finish in WB; INTR is not sampled here so the load is
          // never split by an interrupt.
          bus.memRDEN2 = 1'b1;
          state_d      = ST_WB;
        end else begin
          retire      = 1'b1;
          bus.PCWrite = 1'b1;
          state_d     = bus.INTR ? ST_INTR : ST_FETCH;
          case (bus.opcode)
            OP_STORE:  bus.memWE2 = 1'b1;
            OP_BRANCH: ;
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_REG:
              bus.regWrite = 1'b1;
            OP_SYSTEM: begin
              if (bus.func3 == 3'b000) begin
                bus.mret_exec = 1'b1;
              end else begin
                bus.regWrite = 1'b1;
                bus.csr_WE   = 1'b1;
              end
            end
            default: ;  // unknown opcode executes as a NOP
          endcase
        end
      end

      ST_WB: begin
        retire       = 1'b1;
        bus.regWrite = 1'b1;
        bus.PCWrite  = 1'b1;
        state_d      = bus.INTR ? ST_INTR : ST_FETCH;
      end

      ST_INTR: begin
        bus.int_taken = 1'b1;
        bus.PCWrite   = 1'b1;
        state_d       = ST_FETCH;
      end

      default: state_d = ST_INIT;
    endcase
  end

  assign bus.instret = instret_q;

endmodule
